// File: rtl/uart_tx_fifo_rd.sv
// uart_tx_fifo_rd: UART transmitter that pops words from a FIFO and sends 8N1-style frames at 16x oversampling.
module uart_tx_fifo_rd #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy
);
    localparam int NW = ($clog2(DBIT) < 3) ? 3 : $clog2(DBIT);
    // Tick counter widens beyond 4 bits only when the stop bit needs more than 16 ticks.
    localparam int SW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
    localparam logic [SW-1:0] S_LAST  = SW'(15);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    assign rd      = !reset && state == IDLE && !empty;
    assign tx_busy = state != IDLE;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            tx    <= 1'b1;
        end else begin
            tx <= (state == START) ? 1'b0 : (state == DATA) ? b[0] : 1'b1;
            case (state)
                IDLE:
                    if (!empty) begin
                        b     <= r_data;
                        s     <= '0;
                        state <= START;
                    end
                START:
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                        end else s <= s + 1'b1;
                    end
                DATA:
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= b >> 1;
                            n <= n + 1'b1;
                            if (n == N_LAST) state <= STOP;
                        end else s <= s + 1'b1;
                    end
                STOP:
                    if (s_tick) begin
                        if (s == SB_LAST) state <= IDLE;
                        else s <= s + 1'b1;
                    end
            endcase
        end
endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// tb_uart_tx_fifo_rd: directed + random frames checked against a tick-counting frame model and a FIFO queue.
module tb_uart_tx_fifo_rd;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst, sel, s_tick, empty;
    logic [7:0] r_data;
    logic       rd0, tx0, bz0, rd1, tx1, bz1;
    logic       rd, tx, tx_busy;
    assign rd      = sel ? rd1 : rd0;
    assign tx      = sel ? tx1 : tx0;
    assign tx_busy = sel ? bz1 : bz0;
    uart_tx_fifo_rd #(.DBIT(8), .SB_TICK(16)) dut0 (
        .clk(clk), .reset(rst | sel), .s_tick(s_tick), .empty(empty), .r_data(r_data),
        .rd(rd0), .tx(tx0), .tx_busy(bz0)
    );
    uart_tx_fifo_rd #(.DBIT(8), .SB_TICK(32)) dut1 (
        .clk(clk), .reset(rst | ~sel), .s_tick(s_tick), .empty(empty), .r_data(r_data),
        .rd(rd1), .tx(tx1), .tx_busy(bz1)
    );
    logic [7:0] q[$];
    int         rd_cyc[$];
    int         errors = 0, checks = 0;
    int         period = 1, tcnt = 0, k = 0, sb = 16, cyc_n = 0, frames = 0;
    int         chg_cnt = 0, last_chg = 0;
    bit         in_frame = 0, gap_chk = 0;
    logic       prev_tx = 1'b1;
    logic [7:0] word = '0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic start_gap();
        gap_chk = 1;
        chg_cnt = 0;
        prev_tx = 1'b1;
    endtask
    // One clock: drive inputs at negedge, check rd before the edge, advance the model, check outputs after.
    task automatic cyc();
        bit rd_exp;
        @(negedge clk);
        s_tick = (tcnt == period - 1);
        empty  = (q.size() == 0);
        r_data = empty ? 8'($urandom) : q[0];
        #1;
        rd_exp = !rst && !in_frame && !empty;
        chk("rd", rd, rd_exp);
        @(posedge clk);
        #1;
        cyc_n++;
        tcnt = (tcnt == period - 1) ? 0 : tcnt + 1;
        if (rst) begin
        end else if (rd_exp) begin
            in_frame = 1;
            k        = 0;
            word     = q.pop_front();
            rd_cyc.push_back(cyc_n);
        end else if (in_frame && s_tick) begin
            k++;
            if (k < 144 && k % 16 == 8) chk("tx_bit", tx, (k < 16) ? 1'b0 : word[k/16-1]);
            if (k == 144 + sb / 2) chk("tx_stop", tx, 1);
            if (k == 144 + sb) begin
                in_frame = 0;
                gap_chk  = 0;
                frames++;
            end
        end
        chk("busy", tx_busy, in_frame);
        if (!in_frame) chk("tx_idle", tx, 1);
        if (gap_chk && in_frame && tx !== prev_tx) begin
            chg_cnt++;
            if (chg_cnt >= 3) chk("bit_len", cyc_n - last_chg, 16 * period);
            last_chg = cyc_n;
        end
        prev_tx = tx;
    endtask
    task automatic drain(input int max);
        int c = 0;
        while ((in_frame || q.size() > 0) && c < max) begin
            cyc();
            c++;
        end
        chk("drain", in_frame || q.size() > 0, 0);
    endtask
    initial begin
        int f0;
        rst = 1; sel = 0; s_tick = 0; empty = 1; r_data = '0;
        q.push_back(8'hC4);
        repeat (3) cyc();
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        q.delete();
        rst = 0;
        repeat (1000) cyc();
        f0 = frames;
        start_gap();
        q.push_back(8'h55);
        drain(2000);
        chk("frame_55", frames, f0 + 1);
        rd_cyc.delete();
        q.push_back(8'hA3);
        q.push_back(8'h0F);
        drain(2000);
        chk("b2b_rds", rd_cyc.size(), 2);
        if (rd_cyc.size() == 2) chk("rd_gap", rd_cyc[1] - rd_cyc[0], 161);
        repeat (5) cyc();
        sel = 1; sb = 32;
        repeat (2) cyc();
        rd_cyc.delete();
        q.push_back(8'hFF);
        repeat (100) cyc();
        chk("sb32_busy_mid", tx_busy, 1);
        drain(2000);
        chk("sb32_len", rd_cyc.size(), 1);
        sel = 0; sb = 16;
        repeat (2) cyc();
        q.push_back(8'($urandom));
        for (int i = 0; i < 3000 && !(in_frame && k == 69); i++) cyc();
        chk("reach_bit3", k, 69);
        #2 rst = 1;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_rd", rd, 0);
        in_frame = 0;
        gap_chk  = 0;
        q.push_back(8'h3C);
        repeat (4) cyc();
        chk("held_word", q.size(), 1);
        rst = 0;
        rd_cyc.delete();
        cyc();
        chk("rst_restart", rd_cyc.size(), 1);
        drain(2000);
        period = 5; tcnt = 0;
        start_gap();
        q.push_back(8'h55);
        repeat (300) cyc();
        q.push_back(8'h96);
        drain(4000);
        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(1, 40)) cyc();
            sel = 1'($urandom_range(0, 1));
            sb = sel ? 32 : 16;
            period = $urandom_range(1, 3);
            tcnt = 0;
            cyc();
            q.push_back(8'($urandom));
            repeat ($urandom_range(0, 300)) cyc();
            q.push_back(8'($urandom));
            drain(4000);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_rd.md
UART_TX_FIFO_RD -- requirements
Module: uart_tx_fifo_rd

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, oversampling ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_tick  input  1  one-clk-wide pulse at 16x baud rate.
REQ-006 SHALL have port empty  input  1  FIFO empty flag; 0 = r_data holds the head word.
REQ-007 SHALL have port r_data  input  DBIT  FIFO head word, valid while empty = 0.
REQ-008 SHALL have port rd  output  1  FIFO pop strobe, one clk wide.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; plus a 4-bit tick counter s, a bit counter n (width ceil(log2(DBIT)), minimum 3), a DBIT-bit shift register b, and a registered tx bit.
REQ-012 IDLE: tx = 1; if empty = 0, SHALL latch r_data into b, assert rd in that same cycle, clear s, and go to START next clk.
REQ-013 rd SHALL be high only in the IDLE cycle described in REQ-012: exactly one pulse per frame, never while empty = 1.
REQ-014 START: tx = 0; on each s_tick, s increments; on s_tick with s = 15, SHALL clear s and n and go to DATA.
REQ-015 DATA: tx = b[0] (LSB first); on s_tick with s = 15, SHALL shift b right by one, clear s, and increment n; on that same event with n = DBIT-1, SHALL go to STOP instead.
REQ-016 STOP: tx = 1; on s_tick with s = SB_TICK-1, SHALL go to IDLE.
REQ-017 Clk cycles without s_tick SHALL leave s, n, b and the state unchanged.
REQ-018 tx SHALL be registered: the line value for a state appears one clk after entering that state, and tx SHALL be glitch-free.
REQ-019 tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-020 Back-to-back frames: when STOP exits to IDLE and empty = 0, the next word SHALL be popped in the first IDLE cycle, so the line has no idle gap beyond that one clk.
REQ-021 empty and r_data changes outside IDLE SHALL have no effect on the frame in progress, which uses the latched b.
REQ-022 Frame length SHALL be exactly 16*(1+DBIT) + SB_TICK s_tick pulses from entering START to returning to IDLE.
REQ-023 s and n SHALL wrap only through explicit clearing and SHALL never overflow in normal operation.

Reset
REQ-024 While reset = 1, SHALL force state = IDLE, s = 0, n = 0, b = 0, tx = 1, rd = 0, tx_busy = 0, independent of clk.
REQ-025 Reset mid-frame SHALL abort the frame immediately (tx = 1 asynchronously) without popping the FIFO.
REQ-026 After reset deasserts with empty = 0, SHALL pop and start a frame on the first clk edge.

Verification
REQ-027 Bench SHALL cover a single frame: DBIT = 8, r_data = 0x55, empty 1->0 -> one rd pulse; tx shows 0, then 1,0,1,0,1,0,1,0, then 1, each for 16 s_ticks; tx_busy high for 160 ticks.
REQ-028 Bench SHALL cover back-to-back frames: FIFO holds 0xA3 and 0x0F -> two rd pulses 160 ticks + 1 clk apart; bits match LSB first; tx never goes low between the stop bit and the next start bit except at the start edge.
REQ-029 Bench SHALL cover the empty guard: empty held at 1 for 1000 clks -> rd = 0, tx = 1, tx_busy = 0 throughout.
REQ-030 Bench SHALL cover stop length: SB_TICK = 32, r_data = 0xFF -> stop bit high for 32 ticks; total frame length 176 ticks.
REQ-031 Bench SHALL cover reset mid-frame: assert reset during DATA bit 3 -> tx = 1 and tx_busy = 0 within the same cycle, no rd; after release with empty = 0, a fresh frame starts with one rd.
REQ-032 Bench SHALL cover a sparse tick: s_tick every 5 clks -> each bit lasts 80 clks and the data is unchanged; r_data changed mid-frame -> transmitted bits are unaffected.
